// File: rtl/psum_acc_ctrl_pkg.sv
// Shared definitions for the partial-sum accumulate/ReLU sequencer:
// state encoding, mode constants and default widths.
package psum_acc_ctrl_pkg;

    localparam int PSUM_ADDR_W = 11;
    localparam int PSUM_CNT_W  = 11;

    localparam logic MODE_ACC  = 1'b0;
    localparam logic MODE_RELU = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        RD   = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } psum_state_e;

endpackage

// File: rtl/psum_acc_ctrl_if.sv
// Command, status, output-FIFO and PSUM SRAM signals of the sequencer.
// master = the sequencer, slave = the surrounding datapath/command source.
interface psum_acc_ctrl_if
    import psum_acc_ctrl_pkg::*;
#(
    parameter int ADDR_W = PSUM_ADDR_W,
    parameter int CNT_W  = PSUM_CNT_W
);
    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  num_vec;
    logic              ofifo_valid;
    logic              ofifo_rd;
    logic              CEN_pmem;
    logic              WEN_pmem;
    logic [ADDR_W-1:0] A_pmem;
    logic              acc;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  vec_cnt;

    modport master (
        input  start, mode, base_addr, num_vec, ofifo_valid,
        output ofifo_rd, CEN_pmem, WEN_pmem, A_pmem, acc, busy, done, vec_cnt
    );

    modport slave (
        output start, mode, base_addr, num_vec, ofifo_valid,
        input  ofifo_rd, CEN_pmem, WEN_pmem, A_pmem, acc, busy, done, vec_cnt
    );

endinterface

// File: rtl/psum_acc_ctrl.sv
// Partial-sum sequencer: ACC passes read-modify-write psum + ofifo through the
// SFP, RELU passes rewrite each PSUM word with its ReLU. All outputs are flops.
module psum_acc_ctrl
    import psum_acc_ctrl_pkg::*;
#(
    parameter int ADDR_W = PSUM_ADDR_W,
    parameter int CNT_W  = PSUM_CNT_W
)(
    input  logic             clk,
    input  logic             reset,
    psum_acc_ctrl_if.master  bus
);

    psum_state_e       state_r, state_s;
    logic              mode_r, mode_s;
    logic [CNT_W-1:0]  num_vec_r, num_vec_s;
    logic [ADDR_W-1:0] cur_addr_r, cur_addr_s;
    logic [CNT_W-1:0]  vec_cnt_r, vec_cnt_s;
    logic [CNT_W-1:0]  cnt_inc_s;

    logic              cen_r, cen_s;
    logic              wen_r, wen_s;
    logic [ADDR_W-1:0] a_r, a_s;
    logic              ofifo_rd_r, ofifo_rd_s;
    logic              acc_r, acc_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;

    assign cnt_inc_s = vec_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

    // Next-state, latched pass parameters and address/vector counters.
    always_comb begin
        state_s    = state_r;
        mode_s     = mode_r;
        num_vec_s  = num_vec_r;
        cur_addr_s = cur_addr_r;
        vec_cnt_s  = vec_cnt_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    mode_s     = bus.mode;
                    num_vec_s  = bus.num_vec;
                    cur_addr_s = bus.base_addr;
                    vec_cnt_s  = {CNT_W{1'b0}};
                    if (bus.num_vec == {CNT_W{1'b0}}) begin
                        state_s = DONE;
                    end else if (bus.mode == MODE_ACC) begin
                        state_s = WAIT;
                    end else begin
                        state_s = RD;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (bus.ofifo_valid) begin
                    state_s = RD;
                end else begin
                    state_s = WAIT;
                end
            end
            RD: begin
                state_s = WR;
            end
            WR: begin
                vec_cnt_s  = cnt_inc_s;
                // Address wraps naturally at 2^ADDR_W.
                cur_addr_s = cur_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                if (cnt_inc_s == num_vec_r) begin
                    state_s = DONE;
                end else if (mode_r == MODE_ACC) begin
                    state_s = WAIT;
                end else begin
                    state_s = RD;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up with state_r.
    always_comb begin
        cen_s      = 1'b1;
        wen_s      = 1'b1;
        a_s        = {ADDR_W{1'b0}};
        ofifo_rd_s = 1'b0;
        acc_s      = 1'b0;
        busy_s     = (state_s != IDLE);
        done_s     = (state_s == DONE);
        case (state_s)
            RD: begin
                cen_s = 1'b0;
                a_s   = cur_addr_s;
            end
            WR: begin
                cen_s      = 1'b0;
                wen_s      = 1'b0;
                a_s        = cur_addr_s;
                acc_s      = (mode_s == MODE_ACC);
                ofifo_rd_s = (mode_s == MODE_ACC);
            end
            default: begin
                cen_s = 1'b1;
            end
        endcase
    end

    // State, counters and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            mode_r     <= MODE_ACC;
            num_vec_r  <= {CNT_W{1'b0}};
            cur_addr_r <= {ADDR_W{1'b0}};
            vec_cnt_r  <= {CNT_W{1'b0}};
            cen_r      <= 1'b1;
            wen_r      <= 1'b1;
            a_r        <= {ADDR_W{1'b0}};
            ofifo_rd_r <= 1'b0;
            acc_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            mode_r     <= mode_s;
            num_vec_r  <= num_vec_s;
            cur_addr_r <= cur_addr_s;
            vec_cnt_r  <= vec_cnt_s;
            cen_r      <= cen_s;
            wen_r      <= wen_s;
            a_r        <= a_s;
            ofifo_rd_r <= ofifo_rd_s;
            acc_r      <= acc_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    assign bus.CEN_pmem = cen_r;
    assign bus.WEN_pmem = wen_r;
    assign bus.A_pmem   = a_r;
    assign bus.ofifo_rd = ofifo_rd_r;
    assign bus.acc      = acc_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.vec_cnt  = vec_cnt_r;

endmodule

// File: tb/tb_psum_acc_ctrl.sv
// Directed bench for psum_acc_ctrl: per-cycle monitor logs SRAM writes, pops and
// done pulses; each scenario compares the log against hand-computed values.
module tb_psum_acc_ctrl;
    import psum_acc_ctrl_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    psum_acc_ctrl_if #(.ADDR_W(11), .CNT_W(11)) bus ();

    psum_acc_ctrl #(.ADDR_W(11), .CNT_W(11)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec     = 0;
    int n_err     = 0;
    int cyc       = 0;
    int start_cyc = 0;
    int done_cyc  = 0;
    int n_done    = 0;
    int n_pop     = 0;
    int bad_pop   = 0;
    int cen_act   = 0;
    int wr_addr[$];
    int wr_acc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: advance past the edge, then log what the DUT drives this cycle.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.CEN_pmem == 1'b0) cen_act++;
        if (bus.CEN_pmem == 1'b0 && bus.WEN_pmem == 1'b0) begin
            wr_addr.push_back(int'(bus.A_pmem));
            wr_acc.push_back(int'(bus.acc));
        end
        if (bus.ofifo_rd) begin
            n_pop++;
            if (bus.WEN_pmem !== 1'b0) bad_pop++;
        end
        if (bus.done) begin
            n_done++;
            done_cyc = cyc;
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_acc.delete();
        n_pop   = 0;
        bad_pop = 0;
        cen_act = 0;
    endtask

    task automatic do_start(input logic m, input int base, input int n);
        bus.mode      = m;
        bus.base_addr = 11'(base);
        bus.num_vec   = 11'(n);
        bus.start     = 1'b1;
        step();
        start_cyc = cyc;
        bus.start = 1'b0;
    endtask

    task automatic run_to_done(input string tag, input int budget);
        int d0;
        d0 = n_done;
        for (int i = 0; i < budget && n_done == d0; i++) step();
        check(tag, 32'(n_done != d0), 32'd1);
    endtask

    task automatic check_wr(input string tag, input int base, input int n, input int acc_exp);
        check({tag, "_nwr"}, 32'(wr_addr.size()), 32'(n));
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            check({tag, "_addr"}, 32'(wr_addr[i]), 32'((base + i) % 2048));
            check({tag, "_acc"}, 32'(wr_acc[i]), 32'(acc_exp));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cen"}, 32'(bus.CEN_pmem), 32'd1);
        check({tag, "_wen"}, 32'(bus.WEN_pmem), 32'd1);
        check({tag, "_a"}, 32'(bus.A_pmem), 32'd0);
        check({tag, "_rd"}, 32'(bus.ofifo_rd), 32'd0);
        check({tag, "_acc"}, 32'(bus.acc), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_cnt"}, 32'(bus.vec_cnt), 32'd0);
    endtask

    initial begin
        int found;
        int d0;
        bus.start       = 1'b0;
        bus.mode        = MODE_ACC;
        bus.base_addr   = 11'd0;
        bus.num_vec     = 11'd0;
        bus.ofifo_valid = 1'b0;

        step();
        step();
        check_reset_outputs("rst");
        reset = 1'b0;
        step();

        // 1: ACC base 5, 4 vectors, FIFO always ready
        clear_log();
        bus.ofifo_valid = 1'b1;
        do_start(MODE_ACC, 5, 4);
        run_to_done("t1_done", 40);
        check("t1_lat", 32'(done_cyc - start_cyc), 32'd12);
        check_wr("t1", 5, 4, 1);
        check("t1_pops", 32'(n_pop), 32'd4);
        check("t1_badpop", 32'(bad_pop), 32'd0);
        check("t1_cnt", 32'(bus.vec_cnt), 32'd4);
        check("t1_busy", 32'(bus.busy), 32'd1);
        step();
        check("t1_done_pulse", 32'(bus.done), 32'd0);
        check("t1_idle", 32'(bus.busy), 32'd0);
        check("t1_cnt_hold", 32'(bus.vec_cnt), 32'd4);

        // 2: ACC with FIFO empty for 10 cycles
        clear_log();
        bus.ofifo_valid = 1'b0;
        do_start(MODE_ACC, 100, 2);
        for (int i = 0; i < 10; i++) step();
        check("t2_busy", 32'(bus.busy), 32'd1);
        check("t2_cen_idle", 32'(cen_act), 32'd0);
        check("t2_nopop", 32'(n_pop), 32'd0);
        bus.ofifo_valid = 1'b1;
        step();
        check("t2_rd_cen", 32'(bus.CEN_pmem), 32'd0);
        check("t2_rd_wen", 32'(bus.WEN_pmem), 32'd1);
        check("t2_rd_a", 32'(bus.A_pmem), 32'd100);
        run_to_done("t2_done", 40);
        check_wr("t2", 100, 2, 1);
        check("t2_pops", 32'(n_pop), 32'd2);
        check("t2_cnt", 32'(bus.vec_cnt), 32'd2);
        step();

        // 3: RELU across the address wrap
        clear_log();
        bus.ofifo_valid = 1'b0;
        do_start(MODE_RELU, 2046, 3);
        run_to_done("t3_done", 40);
        check("t3_lat", 32'(done_cyc - start_cyc), 32'd6);
        check_wr("t3", 2046, 3, 0);
        check("t3_nopop", 32'(n_pop), 32'd0);
        check("t3_cnt", 32'(bus.vec_cnt), 32'd3);
        step();

        // 4: empty pass
        clear_log();
        do_start(MODE_ACC, 7, 0);
        check("t4_done", 32'(bus.done), 32'd1);
        check("t4_busy", 32'(bus.busy), 32'd1);
        step();
        check("t4_done_pulse", 32'(bus.done), 32'd0);
        check("t4_idle", 32'(bus.busy), 32'd0);
        check("t4_cen", 32'(cen_act), 32'd0);
        check("t4_cnt", 32'(bus.vec_cnt), 32'd0);

        // 5: second start during a pass is ignored
        clear_log();
        bus.ofifo_valid = 1'b1;
        do_start(MODE_ACC, 20, 4);
        step();
        step();
        bus.mode      = MODE_RELU;
        bus.base_addr = 11'd50;
        bus.num_vec   = 11'd7;
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        run_to_done("t5_done", 40);
        check_wr("t5", 20, 4, 1);
        check("t5_pops", 32'(n_pop), 32'd4);
        check("t5_cnt", 32'(bus.vec_cnt), 32'd4);
        step();

        // 6: reset during WR of the second vector, then a fresh pass
        clear_log();
        do_start(MODE_ACC, 30, 4);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            step();
            if (wr_addr.size() == 2 && bus.WEN_pmem == 1'b0) found = 1;
        end
        check("t6_reach_wr2", 32'(found), 32'd1);
        check("t6_wr2_addr", 32'(bus.A_pmem), 32'd31);
        d0 = n_done;
        reset = 1'b1;
        step();
        check_reset_outputs("t6_rst");
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("t6_no_done", 32'(n_done - d0), 32'd0);
        check("t6_idle", 32'(bus.busy), 32'd0);
        clear_log();
        do_start(MODE_ACC, 40, 2);
        run_to_done("t6_done", 40);
        check_wr("t6", 40, 2, 1);
        check("t6_pops", 32'(n_pop), 32'd2);
        check("t6_cnt", 32'(bus.vec_cnt), 32'd2);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
